// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order WB stage
// and a long-latency late-result path (divider, uncached load). Late results
// wait in a small FIFO until the port is free. A starvation counter forces a
// drain and stalls WB for one cycle when the FIFO has lost too often.
// Busy-query outputs let decode detect hazards against pending late writes.
//
// Optional feature macro: WB_ARB_BYPASS_EN
//   defined   -> a late result arriving while the port is idle and the FIFO
//                is empty is written in the same cycle (zero-latency bypass)
//   undefined -> every accepted late result is queued first
//
// Parameters:
//   DEPTH       late-result FIFO entries (power of 2, 2..8)
//   STARVE_MAX  lost arbitrations tolerated before a forced drain (1..15)
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   WB_Valid/WB_Dst/WB_Result    WB stage write request
//   LR_Valid/LR_Dst/LR_Data      late-result offer
//   LR_Ready                     late result accepted (!full && !rst)
//   RF_We/RF_Waddr/RF_Wdata      register-file write port
//   WB_Stall                     WB lost the port and must hold
//   Q_Rs/Q_Rt                    decode source-register queries
//   Q_RsBusy/Q_RtBusy            queried register has a pending late write

module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_Valid,
  input  logic [4:0]  WB_Dst,
  input  logic [31:0] WB_Result,
  input  logic        LR_Valid,
  input  logic [4:0]  LR_Dst,
  input  logic [31:0] LR_Data,
  output logic        LR_Ready,
  output logic        RF_We,
  output logic [4:0]  RF_Waddr,
  output logic [31:0] RF_Wdata,
  output logic        WB_Stall,
  input  logic [4:0]  Q_Rs,
  input  logic [4:0]  Q_Rt,
  output logic        Q_RsBusy,
  output logic        Q_RtBusy
);

  localparam int          PW         = $clog2(DEPTH);
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [PW:0] PTR_ONE    = {{PW{1'b0}}, 1'b1};

  // FIFO storage; per-entry valid bits make the busy query a simple scan
  logic [4:0]       dst_mem_r  [DEPTH];
  logic [31:0]      data_mem_r [DEPTH];
  logic [DEPTH-1:0] vld_r;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  logic [PW:0] wr_ptr_r;
  logic [PW:0] rd_ptr_r;
  logic [3:0]  starve_r;

  logic          empty_s;
  logic          full_s;
  logic          accept_s;
  logic          forced_s;
  logic          pop_s;
  logic          push_s;
  logic          bypass_s;
  logic          rs_hit_s;
  logic          rt_hit_s;
  logic [PW-1:0] wr_idx_s;
  logic [PW-1:0] rd_idx_s;

  assign wr_idx_s = wr_ptr_r[PW-1:0];
  assign rd_idx_s = rd_ptr_r[PW-1:0];

  // FIFO status from pointer equality and wrap bit
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_idx_s == rd_idx_s);
  end

  // LR_Ready stays low while full even if the head pops this cycle
  assign LR_Ready = !full_s && !rst;
  assign accept_s = LR_Valid && LR_Ready;
  assign forced_s = !empty_s && (starve_r == STARVE_LIM);

  // Port grant: forced drain > WB > queued head > (optional) bypass > idle
  always_comb begin
    RF_We    = 1'b0;
    RF_Waddr = 5'd0;
    RF_Wdata = 32'd0;
    WB_Stall = 1'b0;
    pop_s    = 1'b0;
    bypass_s = 1'b0;
    if (rst) begin
      RF_We = 1'b0;
    end else if (forced_s) begin
      // queued entries never carry $0, so the head always writes
      pop_s    = 1'b1;
      RF_We    = 1'b1;
      RF_Waddr = dst_mem_r[rd_idx_s];
      RF_Wdata = data_mem_r[rd_idx_s];
      WB_Stall = WB_Valid;
    end else if (WB_Valid) begin
      RF_We    = (WB_Dst != 5'd0);
      RF_Waddr = WB_Dst;
      RF_Wdata = WB_Result;
    end else if (!empty_s) begin
      pop_s    = 1'b1;
      RF_We    = 1'b1;
      RF_Waddr = dst_mem_r[rd_idx_s];
      RF_Wdata = data_mem_r[rd_idx_s];
`ifdef WB_ARB_BYPASS_EN
    end else if (accept_s) begin
      // FIFO is empty here; an accepted $0 result is swallowed by the bypass
      bypass_s = 1'b1;
      RF_We    = (LR_Dst != 5'd0);
      RF_Waddr = LR_Dst;
      RF_Wdata = LR_Data;
`endif
    end else begin
      RF_We = 1'b0;
    end
  end

  // Accepted results to $0 are dropped; bypassed results are not queued
  assign push_s = accept_s && (LR_Dst != 5'd0) && !bypass_s;

  // FIFO payload storage; validity is tracked separately under reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      dst_mem_r[wr_idx_s]  <= LR_Dst;
      data_mem_r[wr_idx_s] <= LR_Data;
    end
  end

  // FIFO pointers, valid bits and starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      vld_r    <= '0;
      starve_r <= 4'd0;
    end else begin
      // push and pop never target the same slot: push needs !full, pop !empty
      if (push_s) begin
        wr_ptr_r           <= wr_ptr_r + PTR_ONE;
        vld_r[wr_idx_s]    <= 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r           <= rd_ptr_r + PTR_ONE;
        vld_r[rd_idx_s]    <= 1'b0;
      end
      if (empty_s || pop_s) begin
        starve_r <= 4'd0;
      end else if (starve_r != STARVE_LIM) begin
        starve_r <= starve_r + 4'd1;
      end
    end
  end

  // Busy query: pending FIFO entry or the late result currently offered
  always_comb begin
    rs_hit_s = 1'b0;
    rt_hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rs_hit_s = rs_hit_s | (vld_r[i] && (dst_mem_r[i] == Q_Rs));
      rt_hit_s = rt_hit_s | (vld_r[i] && (dst_mem_r[i] == Q_Rt));
    end
    Q_RsBusy = !rst && (Q_Rs != 5'd0) &&
               (rs_hit_s || (LR_Valid && (LR_Dst == Q_Rs)));
    Q_RtBusy = !rst && (Q_Rt != 5'd0) &&
               (rt_hit_s || (LR_Valid && (LR_Dst == Q_Rt)));
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter (DEPTH=2, STARVE_MAX=4).
// A table of per-cycle input/expected-output records is driven one record
// per cycle; expected records go through a scoreboard queue and are compared
// on the falling edge. A hand-written sequence then measures the late-write
// latency under continuous WB traffic with a bounded wait.

module tb_wb_port_arbiter;

`ifdef WB_ARB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        WB_Valid;
  logic [4:0]  WB_Dst;
  logic [31:0] WB_Result;
  logic        LR_Valid;
  logic [4:0]  LR_Dst;
  logic [31:0] LR_Data;
  logic        LR_Ready;
  logic        RF_We;
  logic [4:0]  RF_Waddr;
  logic [31:0] RF_Wdata;
  logic        WB_Stall;
  logic [4:0]  Q_Rs;
  logic [4:0]  Q_Rt;
  logic        Q_RsBusy;
  logic        Q_RtBusy;

  wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .WB_Valid(WB_Valid), .WB_Dst(WB_Dst), .WB_Result(WB_Result),
    .LR_Valid(LR_Valid), .LR_Dst(LR_Dst), .LR_Data(LR_Data),
    .LR_Ready(LR_Ready),
    .RF_We(RF_We), .RF_Waddr(RF_Waddr), .RF_Wdata(RF_Wdata),
    .WB_Stall(WB_Stall),
    .Q_Rs(Q_Rs), .Q_Rt(Q_Rt), .Q_RsBusy(Q_RsBusy), .Q_RtBusy(Q_RtBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        wbv;
    logic [4:0]  wbd;
    logic [31:0] wbr;
    logic        lrv;
    logic [4:0]  lrd;
    logic [31:0] lrdata;
    logic [4:0]  qs;
    logic [4:0]  qt;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        st;
    logic        rdy;
    logic        rsb;
    logic        rtb;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input string n, input logic r, input logic wbv,
                     input logic [4:0] wbd, input logic [31:0] wbr,
                     input logic lrv, input logic [4:0] lrd,
                     input logic [31:0] lrdata, input logic [4:0] qs,
                     input logic [4:0] qt, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd,
                     input logic st, input logic rdy, input logic rsb,
                     input logic rtb);
    vec_t v;
    v.name = n; v.rst = r; v.wbv = wbv; v.wbd = wbd; v.wbr = wbr;
    v.lrv = lrv; v.lrd = lrd; v.lrdata = lrdata; v.qs = qs; v.qt = qt;
    v.we = we; v.wa = wa; v.wd = wd; v.st = st; v.rdy = rdy;
    v.rsb = rsb; v.rtb = rtb;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; WB_Valid = v.wbv; WB_Dst = v.wbd; WB_Result = v.wbr;
    LR_Valid = v.lrv; LR_Dst = v.lrd; LR_Data = v.lrdata;
    Q_Rs = v.qs; Q_Rt = v.qt;
  endtask

  initial begin
    vec_t        e;
    logic [41:0] got;
    logic [41:0] want;
    logic [31:0] lat_data;
    bit          found;
    int          lat;

    rst = 1'b1; WB_Valid = 1'b0; WB_Dst = 5'd0; WB_Result = 32'd0;
    LR_Valid = 1'b0; LR_Dst = 5'd0; LR_Data = 32'd0; Q_Rs = 5'd0; Q_Rt = 5'd0;

    //   name               rst   wbv   wbd    wbr           lrv   lrd    lrdata         qs     qt      we    wa     wd             st    rdy   rsb   rtb
    add("reset_hold",       1'b1, 1'b1, 5'd3,  32'h0000AAAA, 1'b1, 5'd7,  32'h00000011, 5'd7,  5'd3,   1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 1'b0);
    add("idle_after_reset", 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd0,   1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0);
    add("lr_first",         1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,   BYP,  5'd5,  32'hDEADBEEF,  1'b0, 1'b1, 1'b1, 1'b0);
    add("lr_second",        1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd0,   !BYP, 5'd5,  32'hDEADBEEF,  1'b0, 1'b1, !BYP, 1'b0);
    add("idle_empty",       1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd0,   1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0);
    add("starve_c0",        1'b0, 1'b1, 5'd3,  32'h00000033, 1'b1, 5'd7,  32'h00000011, 5'd7,  5'd3,   1'b1, 5'd3,  32'h00000033,  1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++)
      add($sformatf("starve_c%0d", i),
                            1'b0, 1'b1, 5'd3,  32'h00000033, 1'b0, 5'd0,  32'h0,        5'd7,  5'd3,   1'b1, 5'd3,  32'h00000033,  1'b0, 1'b1, 1'b1, 1'b0);
    add("forced_drain",     1'b0, 1'b1, 5'd3,  32'h00000033, 1'b0, 5'd0,  32'h0,        5'd7,  5'd3,   1'b1, 5'd7,  32'h00000011,  1'b1, 1'b1, 1'b1, 1'b0);
    add("wb_resume",        1'b0, 1'b1, 5'd3,  32'h00000033, 1'b0, 5'd0,  32'h0,        5'd7,  5'd3,   1'b1, 5'd3,  32'h00000033,  1'b0, 1'b1, 1'b0, 1'b0);
    add("fill_1",           1'b0, 1'b1, 5'd4,  32'h00000044, 1'b1, 5'd9,  32'h00000099, 5'd9,  5'd0,   1'b1, 5'd4,  32'h00000044,  1'b0, 1'b1, 1'b1, 1'b0);
    add("fill_2",           1'b0, 1'b1, 5'd4,  32'h00000044, 1'b1, 5'd10, 32'h000000AA, 5'd9,  5'd10,  1'b1, 5'd4,  32'h00000044,  1'b0, 1'b1, 1'b1, 1'b1);
    add("full_refuse",      1'b0, 1'b1, 5'd4,  32'h00000044, 1'b1, 5'd11, 32'h000000BB, 5'd11, 5'd9,   1'b1, 5'd4,  32'h00000044,  1'b0, 1'b0, 1'b1, 1'b1);
    add("full_wait_1",      1'b0, 1'b1, 5'd4,  32'h00000044, 1'b1, 5'd11, 32'h000000BB, 5'd11, 5'd9,   1'b1, 5'd4,  32'h00000044,  1'b0, 1'b0, 1'b1, 1'b1);
    add("full_wait_2",      1'b0, 1'b1, 5'd4,  32'h00000044, 1'b1, 5'd11, 32'h000000BB, 5'd11, 5'd9,   1'b1, 5'd4,  32'h00000044,  1'b0, 1'b0, 1'b1, 1'b1);
    add("full_drain",       1'b0, 1'b1, 5'd4,  32'h00000044, 1'b1, 5'd11, 32'h000000BB, 5'd11, 5'd9,   1'b1, 5'd9,  32'h00000099,  1'b1, 1'b0, 1'b1, 1'b1);
    add("ready_again",      1'b0, 1'b1, 5'd4,  32'h00000044, 1'b1, 5'd11, 32'h000000BB, 5'd9,  5'd11,  1'b1, 5'd4,  32'h00000044,  1'b0, 1'b1, 1'b0, 1'b1);
    add("drain_10",         1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd10, 5'd11,  1'b1, 5'd10, 32'h000000AA,  1'b0, 1'b0, 1'b1, 1'b1);
    add("drain_11",         1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd10, 5'd11,  1'b1, 5'd11, 32'h000000BB,  1'b0, 1'b1, 1'b0, 1'b1);
    add("drained",          1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd11, 5'd0,   1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0);
    add("lr_dst0",          1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h00000055, 5'd0,  5'd0,   1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0);
    add("dst0_not_queued",  1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd0,   1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0);
    add("wb_dst0",          1'b0, 1'b1, 5'd0,  32'h00000066, 1'b0, 5'd0,  32'h0,        5'd0,  5'd0,   1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0);
    add("pre_rst_1",        1'b0, 1'b1, 5'd4,  32'h00000044, 1'b1, 5'd12, 32'h000000C1, 5'd12, 5'd13,  1'b1, 5'd4,  32'h00000044,  1'b0, 1'b1, 1'b1, 1'b0);
    add("pre_rst_2",        1'b0, 1'b1, 5'd4,  32'h00000044, 1'b1, 5'd13, 32'h000000C2, 5'd12, 5'd13,  1'b1, 5'd4,  32'h00000044,  1'b0, 1'b1, 1'b1, 1'b1);
    add("mid_rst",          1'b1, 1'b1, 5'd4,  32'h00000044, 1'b1, 5'd14, 32'h000000C3, 5'd12, 5'd13,  1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 1'b0);
    add("post_rst",         1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd12, 5'd13,  1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0);
    add("post_rst_idle",    1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd12, 5'd13,  1'b0, 5'd0,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0);

    // Table phase: one record per cycle through the scoreboard queue
    foreach (tbl[k]) begin
      @(posedge clk);
      #1;
      drive(tbl[k]);
      exp_q.push_back(tbl[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      // address/data only matter when a write is expected
      got  = {RF_We, WB_Stall, LR_Ready, Q_RsBusy, Q_RtBusy,
              e.we ? RF_Waddr : 5'd0, e.we ? RF_Wdata : 32'd0};
      want = {e.we, e.st, e.rdy, e.rsb, e.rtb,
              e.we ? e.wa : 5'd0, e.we ? e.wd : 32'd0};
      chk(e.name, {22'd0, got}, {22'd0, want});
    end

    // Latency under continuous WB: accepted at cycle 0, written at cycle 5
    lat_data = $urandom;
    found    = 1'b0;
    lat      = -1;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk);
      #1;
      rst = 1'b0; WB_Valid = 1'b1; WB_Dst = 5'd3; WB_Result = 32'h00000033;
      LR_Valid = (c == 0); LR_Dst = 5'd20; LR_Data = lat_data;
      Q_Rs = 5'd20; Q_Rt = 5'd0;
      @(negedge clk);
      if (RF_We && (RF_Waddr == 5'd20)) begin
        found = 1'b1;
        lat   = c;
        chk("late_data",  {32'd0, RF_Wdata}, {32'd0, lat_data});
        chk("late_stall", {63'd0, WB_Stall}, 64'd1);
      end
    end
    if (!found) begin
      n_checks++;
      $display("FAIL late_timeout: no write to $20 within 10 cycles, expected at cycle 5");
    end else begin
      chk("late_latency", 64'(lat), 64'd5);
    end
    @(posedge clk);
    #1;
    LR_Valid = 1'b0;
    @(negedge clk);
    chk("late_after", {57'd0, RF_We, WB_Stall, Q_RsBusy, RF_Waddr},
        {57'd0, 1'b1, 1'b0, 1'b0, 5'd3});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
